// File: rtl/wb_stage_pipe_pkg.sv
// Writeback-source encodings and write-enable constant shared by the
// writeback stage, its interface and its load extender.
package wb_pkg;
    localparam logic [3:0] WB_ALU   = 4'd0;
    localparam logic [3:0] WB_MEMB  = 4'd1;
    localparam logic [3:0] WB_MEMBU = 4'd2;
    localparam logic [3:0] WB_MEMH  = 4'd3;
    localparam logic [3:0] WB_MEMHU = 4'd4;
    localparam logic [3:0] WB_MEMW  = 4'd5;
    localparam logic [3:0] WB_MEMWU = 4'd6;
    localparam logic [3:0] WB_MEMD  = 4'd7;
    localparam logic [3:0] WB_PC    = 4'd8;
    localparam logic [3:0] WB_CSR   = 4'd9;

    localparam logic REN_S = 1'b1;
endpackage

// File: rtl/wb_stage_pipe_if.sv
// Retire-side valid/ready bundle plus the next-PC valid/ready slot.
// master drives retiring instructions and consumes the next PC.
interface wb_stage_pipe_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int OFFW = $clog2(XLEN/8);
    localparam int AW   = $clog2(NREG);

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [3:0]      in_wb_sel;
    logic [XLEN-1:0] in_alu_out;
    logic [XLEN-1:0] in_csr_rdata;
    logic [XLEN-1:0] in_mem_rdata;
    logic [OFFW-1:0] in_mem_off;
    logic [AW-1:0]   in_wb_addr;
    logic            in_rf_wen;
    logic            in_br_flg;
    logic [XLEN-1:0] in_br_target;
    logic            in_jmp_flg;
    logic            in_ecall;
    logic [XLEN-1:0] in_trap_vector;
    logic            out_pc_valid;
    logic [XLEN-1:0] out_pc;
    logic            out_pc_ready;

    modport master (
        output in_valid, in_pc, in_wb_sel, in_alu_out,
        output in_csr_rdata, in_mem_rdata, in_mem_off,
        output in_wb_addr, in_rf_wen, in_br_flg,
        output in_br_target, in_jmp_flg, in_ecall,
        output in_trap_vector, out_pc_ready,
        input  in_ready, out_pc_valid, out_pc
    );

    modport slave (
        input  in_valid, in_pc, in_wb_sel, in_alu_out,
        input  in_csr_rdata, in_mem_rdata, in_mem_off,
        input  in_wb_addr, in_rf_wen, in_br_flg,
        input  in_br_target, in_jmp_flg, in_ecall,
        input  in_trap_vector, out_pc_ready,
        output in_ready, out_pc_valid, out_pc
    );
endinterface

// File: rtl/wb_stage_pipe_load_ext.sv
// Load data extractor: shifts the byte lane down, then sign/zero
// extends to XLEN according to the writeback source.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN/8)
) (
    input  logic [3:0]      sel,
    input  logic [XLEN-1:0] rdata,
    input  logic [OFFW-1:0] off,
    output logic [XLEN-1:0] data
);
    logic [XLEN-1:0] sh;
    logic            sbit;
    int              w;

    always_comb begin
        sh   = rdata >> {off, 3'b000};
        w    = XLEN;
        sbit = 1'b0;
        case (sel)
            WB_MEMB:  begin w = 8;  sbit = sh[7];  end
            WB_MEMBU: w = 8;
            WB_MEMH:  begin w = 16; sbit = sh[15]; end
            WB_MEMHU: w = 16;
            WB_MEMW:  begin w = 32; sbit = sh[31]; end
            WB_MEMWU: w = 32;
            default:  w = XLEN;
        endcase
        data = sh;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= w) data[i] = sbit;
        end
    end
endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage: register file with bypassed read ports and a
// one-entry next-PC slot. WB_RETIRE_CNT_EN adds a 64-bit retire counter.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          NREG     = 32,
    parameter int          NRD      = 2,
    parameter logic [63:0] SP_INIT  = 64'd1000,
    parameter logic [63:0] RESET_PC = 64'd0,
    localparam int         AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    wb_stage_pipe_if.slave      bus,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]         retire_count
`endif
);
    logic [XLEN-1:0] rf [NREG];
    logic            pc_v;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] ld;
    logic [XLEN-1:0] wdata;
    logic            acc;
    logic            we;

    assign bus.in_ready     = !reset && (!pc_v || bus.out_pc_ready);
    assign bus.out_pc_valid = pc_v;
    assign bus.out_pc       = pc_q;

    assign acc = bus.in_valid && bus.in_ready;
    assign we  = acc && (bus.in_rf_wen == REN_S)
              && (bus.in_wb_addr != '0);
    assign pc4 = bus.in_pc + XLEN'(4);

    wb_load_ext #(.XLEN(XLEN)) u_ext (
        .sel   (bus.in_wb_sel),
        .rdata (bus.in_mem_rdata),
        .off   (bus.in_mem_off),
        .data  (ld)
    );

    always_comb begin
        npc = pc4;
        if (bus.in_br_flg)
            npc = bus.in_br_target;
        else if (bus.in_jmp_flg)
            npc = {bus.in_alu_out[XLEN-1:1], 1'b0};
        else if (bus.in_ecall)
            npc = bus.in_trap_vector;
    end

    always_comb begin
        wdata = bus.in_alu_out;
        case (bus.in_wb_sel)
            WB_MEMB, WB_MEMBU,
            WB_MEMH, WB_MEMHU,
            WB_MEMW, WB_MEMWU: wdata = ld;
            // doubleword loads only exist on RV64
            WB_MEMD: wdata = (XLEN == 64) ? ld : bus.in_alu_out;
            WB_PC:   wdata = pc4;
            WB_CSR:  wdata = bus.in_csr_rdata;
            default: wdata = bus.in_alu_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= (i == 2) ? SP_INIT[XLEN-1:0] : '0;
        end else if (we) begin
            rf[bus.in_wb_addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_v <= 1'b0;
            pc_q <= RESET_PC[XLEN-1:0];
        end else if (acc) begin
            pc_v <= 1'b1;
            pc_q <= npc;
        end else if (bus.out_pc_ready) begin
            pc_v <= 1'b0;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[p*AW +: AW];
        assign rd_data[p*XLEN +: XLEN] =
            (ra == '0)                    ? '0    :
            (we && ra == bus.in_wb_addr)  ? wdata :
                                            rf[ra];
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            retire_count <= '0;
        else if (acc)
            retire_count <= retire_count + 64'd1;
    end
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Randomized and directed bench for wb_stage_pipe against a
// behavioural model of the register file and next-PC slot.
module tb_wb_stage_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_count;
`endif

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] m_rf [32];
    logic        m_v;
    logic [31:0] m_pc;
    logic [63:0] m_cnt;

    always #5 clk = ~clk;

    wb_stage_pipe_if #(.XLEN(32), .NREG(32)) bus ();

    wb_stage_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_wb(
        input logic [3:0] sel, input logic [31:0] pc,
        input logic [31:0] alu, input logic [31:0] csr,
        input logic [31:0] rdata, input logic [1:0] off);
        longint unsigned sh, b, h;
        sh = longint'(rdata) / (longint'(1) << (8 * off));
        b  = sh % 256;
        h  = sh % 65536;
        case (sel)
            4'd1: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            4'd2: return 32'(b);
            4'd3: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            4'd4: return 32'(h);
            4'd5, 4'd6: return 32'(sh);
            4'd8: return pc + 32'd4;
            4'd9: return csr;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] exp_npc();
        if (bus.in_br_flg) return bus.in_br_target;
        if (bus.in_jmp_flg) return bus.in_alu_out & 32'hFFFF_FFFE;
        if (bus.in_ecall) return bus.in_trap_vector;
        return bus.in_pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = (i == 2) ? 32'd1000 : 32'd0;
        m_v   = 1'b0;
        m_pc  = 32'd0;
        m_cnt = 64'd0;
    endtask

    task automatic clr();
        bus.in_valid       = 1'b0;
        bus.in_pc          = '0;
        bus.in_wb_sel      = '0;
        bus.in_alu_out     = '0;
        bus.in_csr_rdata   = '0;
        bus.in_mem_rdata   = '0;
        bus.in_mem_off     = '0;
        bus.in_wb_addr     = '0;
        bus.in_rf_wen      = 1'b0;
        bus.in_br_flg      = 1'b0;
        bus.in_br_target   = '0;
        bus.in_jmp_flg     = 1'b0;
        bus.in_ecall       = 1'b0;
        bus.in_trap_vector = '0;
        bus.out_pc_ready   = 1'b1;
    endtask

    task automatic tick();
        logic        rdy, acc;
        logic [31:0] wd, npc, e;
        logic [4:0]  wa, a;
        #1;
        rdy = !reset && (!m_v || bus.out_pc_ready);
        check("in_ready", 64'(bus.in_ready), 64'(rdy));
        check("pc_valid", 64'(bus.out_pc_valid), 64'(m_v));
        check("out_pc", 64'(bus.out_pc), 64'(m_pc));
        acc = bus.in_valid && rdy;
        wa  = bus.in_wb_addr;
        wd  = exp_wb(bus.in_wb_sel, bus.in_pc, bus.in_alu_out,
                     bus.in_csr_rdata, bus.in_mem_rdata, bus.in_mem_off);
        npc = exp_npc();
        for (int p = 0; p < 2; p++) begin
            a = rd_addr[p*5 +: 5];
            if (a == 0) e = 32'd0;
            else if (acc && bus.in_rf_wen && wa == a) e = wd;
            else e = m_rf[a];
            check("rd_data", 64'(rd_data[p*32 +: 32]), 64'(e));
        end
`ifdef WB_RETIRE_CNT_EN
        check("retire_cnt", retire_count, m_cnt);
`endif
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (acc) begin
            if (bus.in_rf_wen && wa != 0) m_rf[wa] = wd;
            m_v  = 1'b1;
            m_pc = npc;
            m_cnt++;
        end else if (bus.out_pc_ready) begin
            m_v = 1'b0;
        end
        #1;
    endtask

    initial begin
        clr();
        reset   = 1'b1;
        rd_addr = {5'd3, 5'd2};
        bus.in_valid   = 1'b1;
        bus.in_rf_wen  = 1'b1;
        bus.in_wb_addr = 5'd3;
        bus.in_alu_out = 32'h55;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        tick();
        tick();
        check("sp_init", 64'(rd_data[31:0]), 64'd1000);
        check("rst_drop", 64'(rd_data[63:32]), 64'd0);
        check("rst_rdy", 64'(bus.in_ready), 64'd0);
        check("rst_pcv", 64'(bus.out_pc_valid), 64'd0);

        reset = 1'b0;
        clr();
        #1;
        check("rdy_post_rst", 64'(bus.in_ready), 64'd1);

        // sign- and zero-extended byte loads
        bus.in_valid = 1'b1; bus.in_rf_wen = 1'b1;
        bus.in_wb_sel = 4'd1; bus.in_mem_rdata = 32'h0000_8000;
        bus.in_mem_off = 2'd1; bus.in_wb_addr = 5'd5;
        tick();
        bus.in_wb_sel = 4'd2; bus.in_wb_addr = 5'd6;
        tick();
        clr();
        rd_addr = {5'd6, 5'd5};
        #1;
        check("memb", 64'(rd_data[31:0]), 64'hFFFF_FF80);
        check("membu", 64'(rd_data[63:32]), 64'h0000_0080);

        bus.in_valid = 1'b1; bus.in_rf_wen = 1'b1;
        bus.in_alu_out = 32'h1234; bus.in_wb_addr = 5'd7;
        rd_addr = {5'd0, 5'd7};
        #1;
        check("bypass", 64'(rd_data[31:0]), 64'h1234);
        tick();
        bus.in_alu_out = 32'hDEAD; bus.in_wb_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        tick();
        check("x0", 64'(rd_data[31:0]), 64'd0);

        clr();
        bus.in_valid = 1'b1;
        bus.in_br_flg = 1'b1; bus.in_jmp_flg = 1'b1; bus.in_ecall = 1'b1;
        bus.in_br_target = 32'h200;
        tick();
        check("npc_br", 64'(bus.out_pc), 64'h200);
        bus.in_br_flg = 1'b0; bus.in_ecall = 1'b0;
        bus.in_alu_out = 32'h301;
        tick();
        check("npc_jmp", 64'(bus.out_pc), 64'h300);
        bus.in_jmp_flg = 1'b0; bus.in_ecall = 1'b1;
        bus.in_trap_vector = 32'h80;
        tick();
        check("npc_ecall", 64'(bus.out_pc), 64'h80);
        bus.in_ecall = 1'b0; bus.in_pc = 32'hFFFF_FFFC;
        tick();
        check("npc_wrap", 64'(bus.out_pc), 64'h0);

        // back-pressure on the next-PC slot
        clr();
        tick();
        bus.in_valid = 1'b1; bus.in_rf_wen = 1'b1;
        bus.in_wb_addr = 5'd9; bus.in_alu_out = 32'hAA;
        bus.in_pc = 32'h10; bus.out_pc_ready = 1'b0;
        tick();
        bus.in_wb_addr = 5'd10; bus.in_alu_out = 32'hBB;
        rd_addr = {5'd9, 5'd10};
        #1;
        check("stall_rdy", 64'(bus.in_ready), 64'd0);
        tick();
        tick();
        check("stall_drop", 64'(rd_data[31:0]), 64'd0);
        check("stall_keep", 64'(rd_data[63:32]), 64'hAA);
        bus.out_pc_ready = 1'b1; bus.in_pc = 32'h40;
        tick();
        check("pass_pcv", 64'(bus.out_pc_valid), 64'd1);
        check("pass_pc", 64'(bus.out_pc), 64'h44);
        check("pass_wr", 64'(rd_data[31:0]), 64'hBB);

`ifdef WB_RETIRE_CNT_EN
        clr();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt_rst", retire_count, 64'd0);
        for (int i = 0; i < 13; i++) begin
            bus.in_valid = !(i == 2 || i == 5 || i == 9);
            tick();
        end
        check("cnt_10", retire_count, 64'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt_clr", retire_count, 64'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            reset              = ($urandom_range(0, 99) == 0);
            bus.in_valid       = ($urandom_range(0, 3) != 0);
            bus.in_pc          = $urandom;
            bus.in_wb_sel      = 4'($urandom_range(0, 15));
            bus.in_alu_out     = $urandom;
            bus.in_csr_rdata   = $urandom;
            bus.in_mem_rdata   = $urandom;
            bus.in_mem_off     = 2'($urandom_range(0, 3));
            bus.in_wb_addr     = 5'($urandom_range(0, 31));
            bus.in_rf_wen      = ($urandom_range(0, 3) != 0);
            bus.in_br_flg      = ($urandom_range(0, 3) == 0);
            bus.in_br_target   = $urandom;
            bus.in_jmp_flg     = ($urandom_range(0, 3) == 0);
            bus.in_ecall       = ($urandom_range(0, 3) == 0);
            bus.in_trap_vector = $urandom;
            bus.out_pc_ready   = ($urandom_range(0, 3) != 0);
            rd_addr[4:0] = $urandom_range(0, 1) == 1
                         ? bus.in_wb_addr : 5'($urandom_range(0, 31));
            rd_addr[9:5] = 5'($urandom_range(0, 31));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Parametrised writeback stage for the rvcpu core. It accepts retiring instructions over a valid/ready handshake.
- Per instruction: extracts and extends load data by byte offset, selects the writeback source, and writes the integer register file.
- Owns the register file and serves NRD bypassed read ports to decode.
- Computes the redirect/next PC and holds it in a registered valid/ready slot for fetch. This adds back-pressure and XLEN/NREG generality.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- NREG, 32, number of integer registers; power of two, 16 or 32.
- NRD, 2, number of register-file read ports.
- SP_INIT, 1000, reset value of register x2.
- RESET_PC, 0, value of out_pc while in reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  retiring instruction present
- in_ready  out  1  stage can accept
- in_pc  in  XLEN  instruction PC
- in_wb_sel  in  4  writeback source, wb_pkg encoding
- in_alu_out  in  XLEN  ALU result / jump target
- in_csr_rdata  in  XLEN  CSR read data
- in_mem_rdata  in  XLEN  raw aligned memory word
- in_mem_off  in  $clog2(XLEN/8)  byte offset of load within word
- in_wb_addr  in  $clog2(NREG)  destination register
- in_rf_wen  in  1  register write enable
- in_br_flg  in  1  branch taken
- in_br_target  in  XLEN  branch target
- in_jmp_flg  in  1  jump
- in_ecall  in  1  ecall
- in_trap_vector  in  XLEN  trap vector
- out_pc_valid  out  1  next PC available
- out_pc  out  XLEN  next PC
- out_pc_ready  in  1  fetch consumes next PC
- rd_addr  in  NRD*$clog2(NREG)  packed read addresses
- rd_data  out  NRD*XLEN  packed read data, combinational
- retire_count  out  64  only with WB_RETIRE_CNT_EN

Behaviour:
- Accept = in_valid && in_ready.
- in_ready = !reset && (!out_pc_valid || out_pc_ready). This gives a one-entry PC slot with pass-through on consume.
- On accept (same edge):
  - Register file written if in_rf_wen and in_wb_addr != 0.
  - The PC slot loads the next PC and out_pc_valid is set to 1.
- When out_pc_ready && out_pc_valid with no accept in the same cycle, out_pc_valid clears. A simultaneous consume and accept keeps out_pc_valid = 1 with the new PC.
- Next PC priority: in_br_flg ? in_br_target : in_jmp_flg ? {in_alu_out[XLEN-1:1],1'b0} : in_ecall ? in_trap_vector : in_pc+4. Addition is modulo 2^XLEN (wraps).
- Load data:
  - sh = in_mem_rdata >> (8*in_mem_off).
  - MEMB/MEMH/MEMW sign-extend bit 7/15/31; BU/HU/WU zero-extend.
  - MEMD passes sh through; it is valid only when XLEN=64, otherwise treated as ALU.
- Writeback data: PC -> in_pc+4, CSR -> in_csr_rdata, any unlisted encoding -> in_alu_out.
- Read ports, per port:
  - Address 0 returns 0.
  - If an accept writes the same address this cycle, the port returns the write data (write-first bypass).
  - Otherwise it returns the array value.
- x0 is never written and always reads 0.
- Reset (sync):
  - All registers 0 except x2 = SP_INIT.
  - out_pc_valid = 0, out_pc = RESET_PC, in_ready = 0.
  - An inputs-valid write during reset is dropped.
  - Reset mid-handshake discards the pending PC.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: port retire_count (64b) exists. It resets to 0, increments by 1 on every accept, and wraps at 2^64.
- Undefined: neither the port nor the counter logic exists; behaviour is otherwise identical.

Decomposition:
- wb_pkg holds the WB_* encodings: ALU=0, MEMB=1, MEMBU=2, MEMH=3, MEMHU=4, MEMW=5, MEMWU=6, MEMD=7, PC=8, CSR=9. It also holds the REN_S write-enable constant.
- Sub-module wb_load_ext is combinational: shift plus sign/zero extension. It is parametrised by XLEN.

Test Plan:
- Reset -> x2 reads 1000, all other registers 0, out_pc_valid=0, in_ready=0. After reset deasserts, in_ready=1.
- Accept MEMB, rdata=0x0000_8000, off=1, rd=5 -> next cycle x5=0xFFFF_FF80. With MEMBU -> 0x0000_0080.
- Accept ALU rd=7 value 0x1234 while rd_addr[0]=7 -> rd_data[0]=0x1234 in the same cycle. Accept rd=0 -> x0 stays 0.
- Flags br=1, jmp=1, ecall=1, br_target=0x200 -> out_pc=0x200. jmp only, alu_out=0x301 -> 0x300. ecall only, trap_vector=0x80 -> 0x80. pc=0xFFFF_FFFC with no flags -> 0x0.
- Hold out_pc_ready=0 after one accept -> in_ready=0 and a second in_valid is not written. Raise ready -> simultaneous consume and accept, out_pc_valid stays 1 with the new PC.
- WB_RETIRE_CNT_EN defined: 10 accepts with 3 stalled cycles -> retire_count=10. Reset -> 0.
